// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one bit-serial adder slice (two cascaded half adders) between two requesters.
// Optional macro SERIAL_ADD_SUB_EN adds per-requester subtract control (A - B via inverted B and carry-in 1).
module serial_add_sched #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             req0_sub,
`endif
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             req1_sub,
`endif
    output logic             req1_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_id,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never depends on ready, and results hold until taken.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             ptr;
    logic             grant0, grant1, accept;
    logic             sub_sel, sub_q;
    logic             b_bit, s1, c1, s, c2, carry_next;
    logic             last_step;

    // ptr holds the last granted requester; a tie goes to the other one.
    always_comb begin
        grant0 = req0_valid & (~req1_valid | ptr);
        grant1 = req1_valid & (~req0_valid | ~ptr);
    end

    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign accept     = req0_ready | req1_ready;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_sel = req1_ready ? req1_sub : req0_sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub_sel;
        end
    end
`else
    assign sub_sel = 1'b0;
    assign sub_q   = 1'b0;
`endif

    // One full-adder slice built from two cascaded half adders.
    always_comb begin
        b_bit      = b_sh[0] ^ sub_q;
        s1         = a_sh[0] ^ b_bit;
        c1         = a_sh[0] & b_bit;
        s          = s1 ^ carry;
        c2         = s1 & carry;
        carry_next = c1 | c2;
    end

    assign last_step = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (last_step) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh      <= '0;
            b_sh      <= '0;
            sum_sh    <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            ptr       <= 1'b1;
            res_valid <= 1'b0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh   <= req1_ready ? req1_a : req0_a;
                        b_sh   <= req1_ready ? req1_b : req0_b;
                        carry  <= sub_sel;
                        cnt    <= '0;
                        res_id <= req1_ready;
                        ptr    <= req1_ready;
                    end
                end
                SHIFT: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= {s, sum_sh[WIDTH-1:1]};
                    carry  <= carry_next;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        res_cout  <= carry_next;
                        res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign res_sum   = sum_sh;
    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_add_sched.sv
// Directed bench for serial_add_sched (WIDTH=8): single ops, overflow, round-robin ties,
// backpressure, reset mid-operation and, with SERIAL_ADD_SUB_EN, subtraction.
module tb_serial_add_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         res_valid, res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout, res_id, busy;
    logic [1:0]   state_dbg;
`ifdef SERIAL_ADD_SUB_EN
    logic         req0_sub, req1_sub;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    serial_add_sched #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
`ifdef SERIAL_ADD_SUB_EN
        .req0_sub   (req0_sub),
`endif
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
`ifdef SERIAL_ADD_SUB_EN
        .req1_sub   (req1_sub),
`endif
        .req1_ready (req1_ready),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_cout   (res_cout),
        .res_id     (res_id),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Called right after the accept edge; counts edges until res_valid rises.
    task automatic wait_result(input string tag, input logic [W-1:0] exp_sum,
                               input logic exp_cout, input logic exp_id);
        int lat;
        lat = 1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_rdy_shift"}, 32'({req0_ready, req1_ready}), 32'd0);
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W + 1));
        chk({tag, "_sum"}, 32'(res_sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(res_cout), 32'(exp_cout));
        chk({tag, "_id"}, 32'(res_id), 32'(exp_id));
    endtask

    task automatic release_result(input string tag);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        res_ready  = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        req0_sub = 1'b0; req1_sub = 1'b0;
`endif
        tick();
        tick();
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(res_sum), 32'd0);
        chk("rst_cout", 32'(res_cout), 32'd0);
        chk("rst_id", 32'(res_id), 32'd0);
        chk("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick();

        // Single op from requester 0; operands are scrambled after accept.
        req0_valid = 1'b1; req0_a = 8'h5A; req0_b = 8'h33;
        #1;
        chk("single_rdy0", 32'(req0_ready), 32'd1);
        chk("single_rdy1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req0_a = 8'hFF; req0_b = 8'hFF;
        wait_result("single", 8'h8D, 1'b0, 1'b0);
        release_result("single");

        // Overflow from requester 1.
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h01;
        #1;
        chk("ovf_rdy1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        wait_result("ovf", 8'h00, 1'b1, 1'b1);
        release_result("ovf");

        // Three ties in a row: 0, then 1, then 0.
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h90;
        #1;
        chk("tie1_grant", 32'({req0_ready, req1_ready}), 32'b10);
        tick();
        wait_result("tie1", 8'h46, 1'b0, 1'b0);
        release_result("tie1");
        chk("tie2_grant", 32'({req0_ready, req1_ready}), 32'b01);
        tick();
        wait_result("tie2", 8'h10, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 32'(res_valid), 32'd1);
            chk("bp_result", 32'({res_sum, res_cout, res_id}), 32'({8'h10, 1'b1, 1'b1}));
            chk("bp_rdy", 32'({req0_ready, req1_ready}), 32'd0);
            chk("bp_busy", 32'(busy), 32'd1);
        end
        release_result("tie2");
        chk("tie3_grant", 32'({req0_ready, req1_ready}), 32'b10);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_result("tie3", 8'h46, 1'b0, 1'b0);
        release_result("tie3");

        // Reset during bit-step 3 after a requester-0 grant.
        req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22;
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_sum", 32'(res_sum), 32'd0);
        #2;
        rst = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h02;
        req1_valid = 1'b1; req1_a = 8'h07; req1_b = 8'h07;
        #1;
        chk("postrst_grant", 32'({req0_ready, req1_ready}), 32'b10);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_result("postrst", 8'h03, 1'b0, 1'b0);
        release_result("postrst");

`ifdef SERIAL_ADD_SUB_EN
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_sub = 1'b1;
        #1;
        chk("sub_rdy0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0; req0_sub = 1'b0;
        wait_result("sub", 8'hF0, 1'b0, 1'b0);
        release_result("sub");
        req1_valid = 1'b1; req1_a = 8'h30; req1_b = 8'h05; req1_sub = 1'b1;
        #1;
        tick();
        req1_valid = 1'b0; req1_sub = 1'b0;
        wait_result("sub_nb", 8'h2B, 1'b1, 1'b1);
        release_result("sub_nb");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
